backlight_pwm_ramp: RTL and testbench

//   Backlight PWM stage downstream of the LPC backlight/max_backlight registers and the brightness button.

---
 rtl/backlight_pwm_ramp_if.sv | 23 ++
 rtl/backlight_pwm_ramp.sv | 111 +++++++++++
 tb/tb_backlight_pwm_ramp.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/backlight_pwm_ramp_if.sv
// Backlight PWM bundle: brightness controls in, PWM pin and status out.
// master drives bl_en/target/period; slave returns pwm_out/duty_cur/ramp_busy/period_strobe.
interface backlight_pwm_ramp_if #(
    parameter int WIDTH = 32
);
    logic             bl_en;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] period;
    logic             pwm_out;
    logic [WIDTH-1:0] duty_cur;
    logic             ramp_busy;
    logic             period_strobe;

    modport master (
        output bl_en, target, period,
        input  pwm_out, duty_cur, ramp_busy, period_strobe
    );

    modport slave (
        input  bl_en, target, period,
        output pwm_out, duty_cur, ramp_busy, period_strobe
    );
endinterface

// File: rtl/backlight_pwm_ramp.sv
// Backlight PWM with period-aligned shadow loads, target clamp and soft ramp.
// Ports: lclk, lreset (sync, active high), bus (slave: bl_en/target/period in; pwm_out/duty_cur/ramp_busy/period_strobe out).
module backlight_pwm_ramp #(
    parameter int WIDTH     = 32,
    parameter int RAMP_STEP = 1427
) (
    input  logic lclk,
    input  logic lreset,
    backlight_pwm_ramp_if.slave bus
);
    localparam logic [WIDTH-1:0] STEP = WIDTH'(RAMP_STEP);

    typedef enum logic [1:0] {
        S_OFF,
        S_IDLE,
        S_UP,
        S_DOWN
    } mode_t;

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] per_l;
    logic [WIDTH-1:0] tgt_l;
    logic [WIDTH-1:0] duty_q;
    logic             pwm_q;
    logic             strobe_q;

    logic             wrap;
    logic [WIDTH-1:0] tgt_clamp;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] step;
    logic [WIDTH-1:0] duty_nxt;
    mode_t            mode;

    assign wrap = (cnt >= per_l);

    // Target above the period saturates to period+1, which keeps the pin
    // permanently high. Unsigned compare needs no extra bit; the add may
    // wrap only when period is all ones.
    always_comb begin
        tgt_clamp = bus.target;
        if (bus.target > bus.period) begin
            tgt_clamp = bus.period + WIDTH'(1);
        end
    end

    // Ramp mode is decoded from registers; OFF overrides everything.
    always_comb begin
        mode = S_IDLE;
        if (!bus.bl_en) begin
            mode = S_OFF;
        end else if (duty_q < tgt_l) begin
            mode = S_UP;
        end else if (duty_q > tgt_l) begin
            mode = S_DOWN;
        end
    end

    // Step is the smaller of the remaining distance and STEP;
    // STEP of zero means jump straight to the target.
    always_comb begin
        diff     = '0;
        step     = '0;
        duty_nxt = duty_q;
        if (duty_q < tgt_l) begin
            diff = tgt_l - duty_q;
        end else begin
            diff = duty_q - tgt_l;
        end
        if ((STEP == '0) || (diff <= STEP)) begin
            step = diff;
        end else begin
            step = STEP;
        end
        unique case (mode)
            S_OFF:   duty_nxt = '0;
            S_UP:    duty_nxt = duty_q + step;
            S_DOWN:  duty_nxt = duty_q - step;
            default: duty_nxt = duty_q;
        endcase
    end

    always_ff @(posedge lclk) begin
        if (lreset) begin
            cnt      <= '0;
            per_l    <= '0;
            tgt_l    <= '0;
            duty_q   <= '0;
            pwm_q    <= 1'b0;
            strobe_q <= 1'b0;
        end else begin
            strobe_q <= wrap;
            pwm_q    <= bus.bl_en & (cnt < duty_q);
            if (wrap) begin
                cnt   <= '0;
                per_l <= bus.period;
                tgt_l <= tgt_clamp;
            end else begin
                cnt <= cnt + WIDTH'(1);
            end
            // Disable acts at once; ramp moves only on period boundaries.
            if ((mode == S_OFF) || wrap) begin
                duty_q <= duty_nxt;
            end
        end
    end

    assign bus.pwm_out       = pwm_q;
    assign bus.duty_cur      = duty_q;
    assign bus.period_strobe = strobe_q;
    assign bus.ramp_busy     = (mode == S_UP) || (mode == S_DOWN);
endmodule

// File: tb/tb_backlight_pwm_ramp.sv
// Directed bench for backlight_pwm_ramp: jump (step 0) and ramped (step 10) instances.
// Ports exercised: lclk, lreset, full interface bundle on both instances.
module tb_backlight_pwm_ramp;
    logic lclk = 1'b0;
    logic lreset;
    int   tests = 0;
    int   fails = 0;

    always #5 lclk = ~lclk;

    backlight_pwm_ramp_if #(.WIDTH(32)) ifa ();
    backlight_pwm_ramp_if #(.WIDTH(32)) ifb ();

    backlight_pwm_ramp #(.WIDTH(32), .RAMP_STEP(0)) dut_a (
        .lclk   (lclk),
        .lreset (lreset),
        .bus    (ifa)
    );

    backlight_pwm_ramp #(.WIDTH(32), .RAMP_STEP(10)) dut_b (
        .lclk   (lclk),
        .lreset (lreset),
        .bus    (ifb)
    );

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge lclk);
            #1;
        end
    endtask

    task automatic wait_strobe(input int sel, output int n);
        logic s;
        n = 0;
        forever begin
            @(posedge lclk);
            #1;
            n++;
            s = (sel == 0) ? ifa.period_strobe : ifb.period_strobe;
            if (s) break;
            if (n >= 1000) begin
                tests++;
                fails++;
                $error("FAIL strobe_timeout: observed none, expected strobe in 1000");
                break;
            end
        end
    endtask

    task automatic wait_n(input int sel, input int k);
        int n;
        repeat (k) wait_strobe(sel, n);
    endtask

    task automatic count_high(input int sel, input int n, output int c);
        logic p;
        c = 0;
        repeat (n) begin
            @(posedge lclk);
            #1;
            p = (sel == 0) ? ifa.pwm_out : ifb.pwm_out;
            if (p) c++;
        end
    endtask

    initial begin
        int n;
        int c;
        lreset     = 1'b1;
        ifa.bl_en  = 1'b1;
        ifa.period = 32'd99;
        ifa.target = 32'd37;
        ifb.bl_en  = 1'b1;
        ifb.period = 32'd199;
        ifb.target = 32'd0;
        step(2);

        check("rst_pwm",    ifa.pwm_out, 0);
        check("rst_duty",   ifa.duty_cur, 0);
        check("rst_strobe", ifa.period_strobe, 0);
        check("rst_busy",   ifa.ramp_busy, 0);

        lreset = 1'b0;
        step(1);
        check("first_wrap_a", ifa.period_strobe, 1);
        check("first_wrap_b", ifb.period_strobe, 1);
        step(1);
        check("strobe_pulse", ifa.period_strobe, 0);
        check("a_not_yet",    ifa.duty_cur, 0);
        check("a_busy",       ifa.ramp_busy, 1);

        // Step 0 jumps to target on the second wrap.
        wait_strobe(0, n);
        check("a_jump",      ifa.duty_cur, 37);
        check("a_idle",      ifa.ramp_busy, 0);
        count_high(0, 100, c);
        check("a_high_37",   c, 37);

        ifa.target = 32'd150;
        wait_strobe(0, n);
        check("a_hold",      ifa.duty_cur, 37);
        wait_strobe(0, n);
        check("a_clamp",     ifa.duty_cur, 100);
        count_high(0, 100, c);
        check("a_const_hi",  c, 100);

        ifa.target = 32'd99;
        wait_n(0, 2);
        check("a_eq_period", ifa.duty_cur, 99);
        check("a_eq_busy",   ifa.ramp_busy, 0);

        // Ramp 0 -> 100 in steps of 10.
        ifb.target = 32'd100;
        wait_strobe(1, n);
        check("b_latch",     ifb.duty_cur, 0);
        check("b_busy",      ifb.ramp_busy, 1);
        for (int k = 1; k <= 10; k++) begin
            wait_strobe(1, n);
            check($sformatf("b_up_%0d", k), ifb.duty_cur, 10 * k);
        end
        check("b_done",      ifb.ramp_busy, 0);
        count_high(1, 200, c);
        check("b_high_100",  c, 100);

        // Clamp to period+1, then ramp down to zero.
        ifb.target = 32'd5000;
        wait_n(1, 11);
        check("b_clamp",     ifb.duty_cur, 200);
        count_high(1, 200, c);
        check("b_const_hi",  c, 200);
        ifb.target = 32'd0;
        wait_n(1, 20);
        check("b_down_mid",  ifb.duty_cur, 10);
        wait_strobe(1, n);
        check("b_down",      ifb.duty_cur, 0);
        count_high(1, 200, c);
        check("b_const_lo",  c, 0);

        // Disable mid-ramp, then soft restart.
        ifb.target = 32'd100;
        wait_n(1, 6);
        check("b_mid",       ifb.duty_cur, 50);
        step(30);
        check("b_pwm_on",    ifb.pwm_out, 1);
        ifb.bl_en = 1'b0;
        step(1);
        check("off_duty",    ifb.duty_cur, 0);
        check("off_pwm",     ifb.pwm_out, 0);
        check("off_busy",    ifb.ramp_busy, 0);
        wait_strobe(1, n);
        check("off_frozen",  ifb.duty_cur, 0);
        ifb.bl_en = 1'b1;
        wait_strobe(1, n);
        check("soft_1",      ifb.duty_cur, 10);
        wait_strobe(1, n);
        check("soft_2",      ifb.duty_cur, 20);

        // Period write mid-period waits for the current wrap.
        step(50);
        ifb.period = 32'd49;
        wait_strobe(1, n);
        check("per_old",     n, 150);
        wait_strobe(1, n);
        check("per_new",     n, 50);
        wait_strobe(1, n);
        check("per_new2",    n, 50);

        // Synchronous reset pulse mid-period.
        step(20);
        lreset = 1'b1;
        step(1);
        check("rp_duty",     ifb.duty_cur, 0);
        check("rp_pwm",      ifb.pwm_out, 0);
        check("rp_strobe",   ifb.period_strobe, 0);
        check("rp_busy",     ifb.ramp_busy, 0);
        lreset = 1'b0;
        step(1);
        check("rp_wrap",     ifb.period_strobe, 1);
        step(1);
        check("rp_wrap_end", ifb.period_strobe, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
